mips_bus_arbiter: RTL

- Two-master, one-slave arbiter for the Avalon memory-mapped bus.
- Lets the MIPS CPU bus master (m0) share the single memory/testbench slave with a secondary master (m1), such as a debug loader or DMA engine.
- Sits between the mips_cpu_bus Avalon controller port and the memory.
- Uses registered round-robin grant with bus parking, combinational forwarding of the granted master, and saturating per-master transfer counters.

---
 rtl/mips_bus_arbiter.sv | 85 ++++++++
 1 files changed

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: two-master round-robin Avalon-MM arbiter with bus parking and saturating transfer counters
// clk/reset             : system clock, asynchronous active-high reset
// m0_* / m1_*           : master request ports (address, read, write, writedata, byteenable in; waitrequest, readdata out)
// s_*                   : slave port driven by the current owner
// grant                 : one-hot owner (bit0 = m0, bit1 = m1), 00 only before the first grant after reset
// m0_count / m1_count   : completed transfers per master, saturating
module mips_bus_arbiter #(
  parameter int FIRST_PRI = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      m0_address,
  input  logic             m0_read,
  input  logic             m0_write,
  input  logic [31:0]      m0_writedata,
  input  logic [3:0]       m0_byteenable,
  output logic             m0_waitrequest,
  output logic [31:0]      m0_readdata,
  input  logic [31:0]      m1_address,
  input  logic             m1_read,
  input  logic             m1_write,
  input  logic [31:0]      m1_writedata,
  input  logic [3:0]       m1_byteenable,
  output logic             m1_waitrequest,
  output logic [31:0]      m1_readdata,
  output logic [31:0]      s_address,
  output logic             s_read,
  output logic             s_write,
  output logic [31:0]      s_writedata,
  output logic [3:0]       s_byteenable,
  input  logic             s_waitrequest,
  input  logic [31:0]      s_readdata,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] m0_count,
  output logic [CNT_W-1:0] m1_count
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [CNT_W-1:0] m0_count_q, m1_count_q;
  logic             req0, req1, done0, done1, own0, own1;
  assign req0  = m0_read | m0_write;
  assign req1  = m1_read | m1_write;
  assign own0  = grant_q[0];
  assign own1  = grant_q[1];
  assign done0 = own0 & req0 & ~s_waitrequest;
  assign done1 = own1 & req1 & ~s_waitrequest;
  // An owner mid-wait is never preempted; otherwise hand over only if the other side wants the bus.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE)
      state_d = (req0 && req1) ? ((FIRST_PRI != 0) ? OWN1 : OWN0) : req0 ? OWN0 : req1 ? OWN1 : IDLE;
    else if (state_q == OWN0)
      state_d = ((req0 && s_waitrequest) || !req1) ? OWN0 : OWN1;
    else
      state_d = ((req1 && s_waitrequest) || !req0) ? OWN1 : OWN0;
    grant_d = (state_d == OWN0) ? 2'b01 : (state_d == OWN1) ? 2'b10 : 2'b00;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      m0_count_q <= '0;
      m1_count_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      m0_count_q <= m0_count_q + CNT_W'(done0 && ~&m0_count_q);
      m1_count_q <= m1_count_q + CNT_W'(done1 && ~&m1_count_q);
    end
  end
  assign s_address      = own0 ? m0_address    : own1 ? m1_address    : '0;
  assign s_read         = own0 ? m0_read       : own1 & m1_read;
  assign s_write        = own0 ? m0_write      : own1 & m1_write;
  assign s_writedata    = own0 ? m0_writedata  : own1 ? m1_writedata  : '0;
  assign s_byteenable   = own0 ? m0_byteenable : own1 ? m1_byteenable : '0;
  assign m0_waitrequest = own0 ? s_waitrequest : 1'b1;
  assign m1_waitrequest = own1 ? s_waitrequest : 1'b1;
  assign m0_readdata    = own0 ? s_readdata    : '0;
  assign m1_readdata    = own1 ? s_readdata    : '0;
  assign grant          = grant_q;
  assign m0_count       = m0_count_q;
  assign m1_count       = m1_count_q;
endmodule
